inst_rom_responder: RTL and testbench
=====================================

Name: inst_rom_responder

Overview:
Instruction-memory responder for the CPU core's fetch port. It answers the core's fetch requests (chip-enable plus word address) with 32-bit instruction words. It also contains a byte-serial loader FSM that fills the ROM array after reset, before fetches are served. It sits outside the core and drives the core's instruction input from the core's instruction address and ROM chip-enable outputs.

Parameters:
DEPTH_LOG2, 10, log2 of ROM depth in 32-bit words (default 1024 words)
RD_LAT, 0, fetch read latency in cycles, legal 0..3 (0 = combinational read)
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-low
ce_i  input  1  fetch chip-enable from core
addr_i  input  32  fetch byte address from core
inst_o  output  32  instruction word to core
inst_valid_o  output  1  inst_o holds a real ROM word
addr_err_o  output  1  fetch was misaligned or out of range
ld_valid_i  input  1  loader byte valid
ld_byte_i  input  8  loader byte
ld_last_i  input  1  current loader byte is the final byte
ld_ready_o  output  1  loader byte accepted this cycle when high
ld_done_o  output  1  load complete; ROM serving fetches
parity_err_o  output  1  parity mismatch on read (see optional feature)

Behaviour:
- Reset (rst low, asynchronous), all outputs low:
  - state=LOAD, wr_ptr=0, byte_cnt=0, byte assembly register=0.
  - All RD_LAT pipeline stages cleared; inst_o=0, inst_valid_o=0, addr_err_o=0, ld_ready_o=0, ld_done_o=0, parity_err_o=0.
  - ROM array is not reset.
- States: LOAD and RUN. RUN is left only by reset.
- LOAD:
  - ld_ready_o=1 from the first clock after reset release.
  - A byte is accepted on ld_valid_i & ld_ready_o. Little-endian: byte k (k=0..3) goes to bits [8k+7:8k].
  - On the 4th byte: write the word to mem[wr_ptr], increment wr_ptr, clear byte_cnt.
  - ld_last_i on an accepted byte: zero-pad the remaining bytes, write the word, go to RUN next cycle.
  - A write to word 2^DEPTH_LOG2-1 goes to RUN; further bytes are not accepted.
- RUN:
  - ld_done_o=1, ld_ready_o=0; loader inputs are ignored.
- Fetch decode, evaluated in the request cycle:
  - off = addr_i - BASE_ADDR (32-bit wrap).
  - idx = off[DEPTH_LOG2+1:2].
  - in_range = (off[31:DEPTH_LOG2+2] == 0); aligned = (off[1:0] == 0).
- Fetch result for each request:
  - ce_i=0: inst_o=0, inst_valid_o=0, addr_err_o=0.
  - ce_i=1 in LOAD: inst_o=32'h0340_0000 (NOP), inst_valid_o=0, addr_err_o=0. The cycle that transitions LOAD->RUN still counts as LOAD.
  - ce_i=1 in RUN, aligned & in_range: inst_o=mem[idx], inst_valid_o=1, addr_err_o=0.
  - ce_i=1 in RUN, otherwise: inst_o=NOP, inst_valid_o=1, addr_err_o=1.
- Latency:
  - RD_LAT=0: outputs are combinational from the request.
  - RD_LAT=N: the result appears exactly N cycles after the request through an N-stage register pipeline.
  - One request per cycle, no stall, no backpressure.
- Hazards: the array is written only in LOAD and read only in RUN, so no read/write collision exists.
- Reset mid-load: the partial word is discarded and the load restarts at word 0. Words already written remain but are overwritten by the new load.

Optional Feature:
ROM_PARITY_EN
- Defined:
  - Each word stores an extra even-parity bit, computed at write.
  - On a RUN fetch of a valid word, recomputed parity != stored parity sets parity_err_o=1, aligned with inst_o (same latency). inst_o is still the stored word.
  - parity_err_o=0 on all other fetches.
- Undefined: no parity storage; parity_err_o tied 0.

Test Plan:
1. Load bytes 78,56,34,12,EF,BE,AD,DE, ld_last_i on the 8th -> ld_done_o=1 next cycle; fetch 0x0 -> 0x12345678 and fetch 0x4 -> 0xDEADBEEF, each with inst_valid_o=1, addr_err_o=0.
2. Load 5 bytes 01..05 with last on the 5th -> fetch 0x4 returns 0x00000005; ld_ready_o=0 afterward.
3. ce_i=1, addr 0x0 during LOAD -> inst_o=0x03400000, inst_valid_o=0; ce_i=0 in RUN -> inst_o=0.
4. In RUN, fetch 0x2 -> addr_err_o=1, inst_o=NOP; fetch 0x1000 with DEPTH_LOG2=10 -> addr_err_o=1.
5. RD_LAT=2, back-to-back fetches 0x0, 0x4, 0x0 at cycles t, t+1, t+2 -> results at t+2, t+3, t+4, no bubbles.
6. Assert rst after 3 bytes accepted, release, send AA,BB,CC,DD with last -> word0=0xDDCCBBAA. With ROM_PARITY_EN, forcing a stored bit flip -> parity_err_o=1 on that fetch.

Source files
------------

// File: rtl/inst_rom_responder.sv
// Instruction ROM responder for the core fetch port.
// A byte-serial loader fills the array after reset; afterwards the array serves
// fetches with a configurable read latency (RD_LAT register stages, 0 = combinational).
// Optional feature macro: ROM_PARITY_EN (per-word even parity, checked on fetch).
module inst_rom_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned RD_LAT     = 0,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic [31:0] addr_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        addr_err_o,
  input  logic        ld_valid_i,
  input  logic [7:0]  ld_byte_i,
  input  logic        ld_last_i,
  output logic        ld_ready_o,
  output logic        ld_done_o,
  output logic        parity_err_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [31:0] NOP   = 32'h0340_0000;

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

  typedef struct packed {
    logic        par_err;
    logic        addr_err;
    logic        valid;
    logic [31:0] inst;
  } fetch_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           asm_q, asm_d;
  logic                  ld_ready_q, ld_done_q;
  logic                  accept_c;
  logic                  wr_en_c;
  logic [31:0]           wr_word_c;

  logic [31:0] mem [DEPTH];
`ifdef ROM_PARITY_EN
  logic        mem_par [DEPTH];
`endif

  // Loader state and handshake registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LOAD;
      wr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      ld_ready_q <= (state_d == LOAD);
      ld_done_q  <= (state_d == RUN);
    end
  end

  // Loader next-state: little-endian byte assembly, write on 4th or last byte
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    accept_c   = 1'b0;
    wr_en_c    = 1'b0;
    wr_word_c  = asm_q | (32'(ld_byte_i) << {byte_cnt_q, 3'b000});
    case (state_q)
      LOAD: begin
        accept_c = ld_valid_i & ld_ready_q;
        if (accept_c) begin
          if (ld_last_i || (byte_cnt_q == 2'd3)) begin
            wr_en_c    = 1'b1;
            wr_ptr_d   = wr_ptr_q + DEPTH_LOG2'(1);
            byte_cnt_d = '0;
            asm_d      = '0;
            if (ld_last_i || (wr_ptr_q == '1)) begin
              state_d = RUN;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            asm_d      = wr_word_c;
          end
        end
      end
      RUN: begin
        state_d = RUN;
      end
    endcase
  end

  // Array write port, used only while loading; the array itself is not reset
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr_q] <= wr_word_c;
`ifdef ROM_PARITY_EN
      mem_par[wr_ptr_q] <= ^wr_word_c;
`endif
    end
  end

  logic [31:0]           off_c;
  logic [DEPTH_LOG2-1:0] idx_c;
  logic                  in_range_c;
  logic                  aligned_c;
  fetch_t                res_c;

  // Fetch decode and result selection in the request cycle
  always_comb begin
    off_c      = addr_i - BASE_ADDR;
    idx_c      = off_c[DEPTH_LOG2+1:2];
    in_range_c = (off_c[31:DEPTH_LOG2+2] == '0);
    aligned_c  = (off_c[1:0] == 2'b00);
    res_c      = '0;
    if (ce_i) begin
      res_c.inst = NOP;
      if (state_q == RUN) begin
        res_c.valid = 1'b1;
        if (aligned_c && in_range_c) begin
          res_c.inst = mem[idx_c];
`ifdef ROM_PARITY_EN
          res_c.par_err = ((^mem[idx_c]) != mem_par[idx_c]);
`endif
        end else begin
          res_c.addr_err = 1'b1;
        end
      end
    end
  end

  fetch_t out_c;

  generate
    if (RD_LAT == 0) begin : g_comb
      assign out_c = res_c;
    end else begin : g_pipe
      fetch_t pipe_q [RD_LAT];

      // Fixed-latency result pipeline, one request per cycle
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= res_c;
          for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign out_c = pipe_q[RD_LAT-1];
    end
  endgenerate

  assign inst_o       = out_c.inst;
  assign inst_valid_o = out_c.valid;
  assign addr_err_o   = out_c.addr_err;
  assign parity_err_o = out_c.par_err;
  assign ld_ready_o   = ld_ready_q;
  assign ld_done_o    = ld_done_q;

endmodule

// File: tb/tb_inst_rom_responder.sv
// Bench for inst_rom_responder: table vectors, directed loader sequences and
// randomized loads/fetches checked against a word-array reference model.
`timescale 1ns/1ps
module tb_inst_rom_responder;

  localparam int unsigned DEPTH_LOG2 = 10;
  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
  localparam int unsigned RD_LAT     = 2;
  localparam logic [31:0] BASE       = 32'h0000_0000;
  localparam logic [31:0] NOP        = 32'h0340_0000;

  logic        clk;
  logic        rst;
  logic        ce_i;
  logic [31:0] addr_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        addr_err_o;
  logic        ld_valid_i;
  logic [7:0]  ld_byte_i;
  logic        ld_last_i;
  logic        ld_ready_o;
  logic        ld_done_o;
  logic        parity_err_o;

  inst_rom_responder #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .RD_LAT    (RD_LAT),
    .BASE_ADDR (BASE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ce_i        (ce_i),
    .addr_i      (addr_i),
    .inst_o      (inst_o),
    .inst_valid_o(inst_valid_o),
    .addr_err_o  (addr_err_o),
    .ld_valid_i  (ld_valid_i),
    .ld_byte_i   (ld_byte_i),
    .ld_last_i   (ld_last_i),
    .ld_ready_o  (ld_ready_o),
    .ld_done_o   (ld_done_o),
    .parity_err_o(parity_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        valid;
    logic        err;
    logic        par;
    bit          known;
  } exp_t;

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        valid;
    logic        err;
  } vec_t;

  int   n_checks;
  int   n_fail;
  exp_t hist[$];

  // Reference model: ROM contents as a plain word array plus loader progress
  logic [31:0] m_mem [DEPTH];
  bit          m_written [DEPTH];
  logic [31:0] m_word;
  int          m_nbytes;
  int          m_wr;
  int          m_hi;
  int          m_bad_idx;
  bit          m_run;
  bit          m_ready;
  bit          m_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t zexp();
    exp_t e;
    e.inst = 32'h0; e.valid = 1'b0; e.err = 1'b0; e.par = 1'b0; e.known = 1'b1;
    return e;
  endfunction

  function automatic exp_t model_fetch(input logic ce, input logic [31:0] addr);
    exp_t        e;
    logic [31:0] off;
    int          w;
    e = zexp();
    if (!ce) return e;
    e.inst = NOP;
    if (!m_run) return e;
    e.valid = 1'b1;
    off = addr - BASE;
    if ((off % 4 == 0) && (off < 32'(DEPTH * 4))) begin
      w       = int'(off / 4);
      e.inst  = m_mem[w];
      e.known = m_written[w];
      e.par   = (w == m_bad_idx);
    end else begin
      e.err = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rnd_addr();
    int hi;
    hi = (m_hi < 0) ? 0 : m_hi;
    case ($urandom_range(0, 4))
      0, 1:    return BASE + 32'($urandom_range(0, hi) * 4);
      2:       return BASE + 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      3:       return BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 1 << 20) * 4);
      default: return 32'($urandom);
    endcase
  endfunction

  // One clock cycle: drive at posedge+1, check at negedge, advance model, end at posedge+1
  task automatic step(input logic ce, input logic [31:0] addr, input logic lv,
                      input logic [7:0] lb, input logic ll, input bit use_e, input exp_t e_in);
    exp_t e;
    ce_i = ce; addr_i = addr; ld_valid_i = lv; ld_byte_i = lb; ld_last_i = ll;
    e = use_e ? e_in : model_fetch(ce, addr);
    hist.push_back(e);
    @(negedge clk);
    e = hist[hist.size() - 1 - RD_LAT];
    if (hist.size() > RD_LAT + 1) void'(hist.pop_front());
    if (e.known) check("inst_o", inst_o, e.inst);
    check("inst_valid_o", 32'(inst_valid_o), 32'(e.valid));
    check("addr_err_o", 32'(addr_err_o), 32'(e.err));
    check("parity_err_o", 32'(parity_err_o), 32'(e.par));
    check("ld_ready_o", 32'(ld_ready_o), 32'(m_ready));
    check("ld_done_o", 32'(ld_done_o), 32'(m_run));
    m_acc = lv && m_ready;
    if (m_acc) begin
      m_word = m_word | (32'(lb) << (8 * m_nbytes));
      m_nbytes++;
      if ((m_nbytes == 4) || ll) begin
        m_mem[m_wr]     = m_word;
        m_written[m_wr] = 1'b1;
        if (m_wr > m_hi) m_hi = m_wr;
        if (ll || (m_wr == DEPTH - 1)) m_run = 1'b1;
        m_wr++;
        m_word   = 32'h0;
        m_nbytes = 0;
      end
    end
    @(posedge clk);
    #1;
    m_ready = !m_run;
  endtask

  task automatic fetch(input logic ce, input logic [31:0] addr);
    step(ce, addr, 1'b0, 8'h00, 1'b0, 1'b0, zexp());
  endtask

  task automatic fetch_exp(input logic [31:0] addr, input logic [31:0] inst);
    exp_t e;
    e = zexp();
    e.inst = inst; e.valid = 1'b1;
    step(1'b1, addr, 1'b0, 8'h00, 1'b0, 1'b1, e);
  endtask

  task automatic flush();
    repeat (RD_LAT) fetch(1'b0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b0; ce_i = 1'b0; addr_i = 32'h0; ld_valid_i = 1'b0; ld_byte_i = 8'h00; ld_last_i = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst inst_o", inst_o, 32'h0);
      check("rst valid/err/par", {29'h0, inst_valid_o, addr_err_o, parity_err_o}, 32'h0);
      check("rst ready/done", {30'h0, ld_ready_o, ld_done_o}, 32'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    hist.delete();
    repeat (RD_LAT) hist.push_back(zexp());
    m_run = 1'b0; m_ready = 1'b0; m_word = 32'h0; m_nbytes = 0; m_wr = 0;
  endtask

  // Offer one byte (with optional idle gap) until the model says it was taken
  task automatic send_byte(input logic [7:0] b, input logic last);
    int guard;
    guard = 0;
    if ($urandom_range(0, 3) == 0) step(1'($urandom), rnd_addr(), 1'b0, 8'($urandom), 1'b0, 1'b0, zexp());
    do begin
      step(1'($urandom), rnd_addr(), 1'b1, b, last, 1'b0, zexp());
      guard++;
    end while (!m_acc && guard < 4);
    if (!m_acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_byte: byte %h not accepted within %0d cycles", b, guard);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[9];
    logic [7:0]  t1[8];
    exp_t        e;
    int          n;

    n_checks = 0; n_fail = 0; m_hi = -1; m_bad_idx = -1;
    for (int i = 0; i < DEPTH; i++) begin m_written[i] = 1'b0; m_mem[i] = 32'h0; end

    vecs[0] = '{1'b1, 32'h0000_0000, 32'h1234_5678, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0000, 32'h1234_5678, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0002, NOP,           1'b1, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_1000, NOP,           1'b1, 1'b1};
    vecs[6] = '{1'b1, 32'hFFFF_FFFC, NOP,           1'b1, 1'b1};
    vecs[7] = '{1'b1, 32'h0000_0FFD, NOP,           1'b1, 1'b1};
    vecs[8] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 1'b1, 1'b0};

    t1[0] = 8'h78; t1[1] = 8'h56; t1[2] = 8'h34; t1[3] = 8'h12;
    t1[4] = 8'hEF; t1[5] = 8'hBE; t1[6] = 8'hAD; t1[7] = 8'hDE;

    rst = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Fetch while loading returns NOP without valid
    fetch(1'b1, 32'h0);
    fetch(1'b1, 32'h4);

    // Two-word load, then back-to-back table fetches through the latency pipe
    for (int i = 0; i < 8; i++) send_byte(t1[i], 1'(i == 7));
    fetch(1'b0, 32'h0);
    for (int i = 0; i < 9; i++) begin
      e = zexp();
      e.inst = vecs[i].inst; e.valid = vecs[i].valid; e.err = vecs[i].err;
      step(vecs[i].ce, vecs[i].addr, 1'b0, 8'h00, 1'b0, 1'b1, e);
    end
    flush();

    // Short load with zero padding of the trailing word
    do_reset();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'(i == 5));
    fetch_exp(32'h4, 32'h0000_0005);
    fetch_exp(32'h0, 32'h0403_0201);
    step(1'b0, 32'h0, 1'b1, 8'h99, 1'b1, 1'b0, zexp());
    flush();

    // Reset in the middle of a word restarts the load at word 0
    do_reset();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    do_reset();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b1);
    fetch_exp(32'h0, 32'hDDCC_BBAA);
    flush();

    // Random partial loads followed by random fetch traffic
    for (int it = 0; it < 3; it++) begin
      do_reset();
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) send_byte(8'($urandom), 1'(i == n - 1));
      for (int c = 0; c < 150; c++) fetch(1'($urandom), rnd_addr());
    end

    // Fill every word: loader closes itself after the top word
    do_reset();
    for (int i = 0; i < DEPTH * 4; i++) send_byte(8'($urandom), 1'b0);
    for (int c = 0; c < 4; c++) step(1'b1, rnd_addr(), 1'b1, 8'($urandom), 1'($urandom), 1'b0, zexp());
    fetch(1'b1, BASE + 32'((DEPTH - 1) * 4));
    for (int c = 0; c < 300; c++) fetch(1'($urandom), rnd_addr());
    flush();

`ifdef ROM_PARITY_EN
    // Corrupt one stored bit: data comes back as stored, parity error flagged
    dut.mem[5] = dut.mem[5] ^ 32'h0000_0100;
    m_mem[5]   = m_mem[5] ^ 32'h0000_0100;
    m_bad_idx  = 5;
    fetch(1'b1, BASE + 32'd20);
    fetch(1'b1, BASE + 32'd24);
    flush();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
